// File: rtl/c1541_sd_server_pkg.sv
// ============================================================================
// Module      : c1541_pkg
// Description : Shared types and constants for the C1541 SD block server.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package c1541_pkg;

    localparam int BLK_BYTES  = 512;
    localparam int BLK_AW     = 9;
    localparam int MEM_AW_DEF = 24;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_FETCH = 4'd1,
        RD_PUT   = 4'd2,
        RD_GAP   = 4'd3,
        WR_ADDR  = 4'd4,
        WR_WAIT  = 4'd5,
        WR_STORE = 4'd6,
        WR_GAP   = 4'd7,
        DONE     = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/c1541_sd_pacer.sv
// ============================================================================
// Module      : c1541_sd_pacer
// Description : Loadable down-counter used for buffer-latency and pacing waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c1541_sd_pacer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/c1541_sd_server.sv
// ============================================================================
// Module      : c1541_sd_server
// Description : Block responder mapping 512-byte drive requests onto an image memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c1541_sd_server
    import c1541_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int RD_LAT = 2,
    parameter int PACE   = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    input  logic [MEM_AW-10:0] img_blocks,
    input  logic              img_ro,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready
);

    localparam int              c_pw       = 16;
    // WR_ADDR itself is the first latency cycle, so the pacer covers the rest.
    localparam logic [c_pw-1:0] c_lat_load  = c_pw'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
    localparam logic [c_pw-1:0] c_pace_load = c_pw'(PACE);

    state_t              r_state;
    state_t              w_next;
    logic [MEM_AW-10:0]  r_lba;
    logic [BLK_AW-1:0]   r_idx;
    logic                r_in_range;
    logic                r_wr_ok;
    logic                r_ack;
    logic [7:0]          r_dout;
    logic [7:0]          r_mem_din;

    logic                w_accept;
    logic                w_in_range;
    logic                w_last;
    logic                w_zero;
    logic                w_pace_load;
    logic [c_pw-1:0]     w_pace_val;
    logic                w_pace_count;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic                w_buff_wr;
    logic                w_rd_cap;
    logic                w_wr_cap;
    logic                w_adv;

    assign w_accept     = (r_state == IDLE) && (sd_rd || sd_wr);
    assign w_in_range   = sd_lba < 32'(img_blocks);
    assign w_last       = (r_idx == BLK_AW'(BLK_BYTES - 1));
    assign w_pace_load  = (r_state == WR_ADDR) || (r_state == RD_PUT) || (r_state == WR_STORE);
    assign w_pace_val   = (r_state == WR_ADDR) ? c_lat_load : c_pace_load;
    assign w_pace_count = (r_state == WR_WAIT) || (r_state == RD_GAP) || (r_state == WR_GAP);

    c1541_sd_pacer #(
        .WIDTH (c_pw)
    ) u_pacer (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .i_load     (w_pace_load),
        .i_load_val (w_pace_val),
        .i_count    (w_pace_count),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_buff_wr = 1'b0;
        w_rd_cap  = 1'b0;
        w_wr_cap  = 1'b0;
        w_adv     = 1'b0;
        case (r_state)
            IDLE: begin
                if (sd_rd) begin
                    w_next = RD_FETCH;
                end else if (sd_wr) begin
                    w_next = WR_ADDR;
                end
            end
            RD_FETCH: begin
                w_mem_rd = r_in_range;
                if (!r_in_range || mem_ready) begin
                    w_rd_cap = 1'b1;
                    w_next   = RD_PUT;
                end
            end
            RD_PUT: begin
                w_buff_wr = 1'b1;
                w_next    = RD_GAP;
            end
            RD_GAP: begin
                if (w_zero) begin
                    w_adv  = !w_last;
                    w_next = w_last ? DONE : RD_FETCH;
                end
            end
            WR_ADDR: begin
                w_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (w_zero) begin
                    w_wr_cap = 1'b1;
                    w_next   = WR_STORE;
                end
            end
            WR_STORE: begin
                // Read-only or out-of-range writes are silently dropped.
                w_mem_wr = r_wr_ok;
                if (!r_wr_ok || mem_ready) begin
                    w_next = WR_GAP;
                end
            end
            WR_GAP: begin
                if (w_zero) begin
                    w_adv  = !w_last;
                    w_next = w_last ? DONE : WR_ADDR;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_ack      <= 1'b0;
            r_lba      <= '0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_wr_ok    <= 1'b0;
            r_dout     <= 8'h00;
            r_mem_din  <= 8'h00;
        end else begin
            if (w_accept) begin
                r_ack      <= 1'b1;
                r_lba      <= sd_lba[MEM_AW-10:0];
                r_idx      <= '0;
                r_in_range <= w_in_range;
                r_wr_ok    <= w_in_range && !img_ro;
            end
            // Ack stays high through DONE so it is low for exactly the IDLE cycle.
            if (r_state == DONE) begin
                r_ack <= 1'b0;
            end
            if (w_rd_cap) begin
                r_dout <= r_in_range ? mem_dout : 8'h00;
            end
            if (w_wr_cap) begin
                r_mem_din <= sd_buff_din;
            end
            if (w_adv) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sd_ack       = r_ack;
    assign sd_buff_addr = r_idx;
    assign sd_buff_dout = r_dout;
    assign sd_buff_wr   = w_buff_wr;
    assign mem_addr     = {r_lba, r_idx};
    assign mem_rd       = w_mem_rd;
    assign mem_wr       = w_mem_wr;
    assign mem_din      = r_mem_din;

endmodule

`default_nettype wire

// File: doc/c1541_sd_server.md
Name: c1541_sd_server

Overview:
- Serves the block side of the drive's sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* interface; it is the responder to the drive's block requests.
- Maps each 512-byte block request onto a byte-wide disk-image memory, such as an SDRAM-resident image or a simulation model.
- On a read it streams image bytes into the drive's track buffer. On a write it pulls bytes out of the track buffer and stores them to the image.
- Used for HPS-less builds and as the drive-level testbench back end.

Parameters:
- MEM_AW, 24: byte address width of the image memory.
- RD_LAT, 2: cycles from sd_buff_addr change to valid sd_buff_din; the drive buffer read latency.
- PACE, 0: idle cycles inserted between consecutive buffer bytes.

Ports:
- clk_sys  in  1  block clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sd_lba  in  32  block number; sampled when a request is accepted.
- sd_rd  in  1  read request, level.
- sd_wr  in  1  write request, level.
- sd_ack  out  1  high for the whole block transfer.
- sd_buff_addr  out  9  byte index within the block.
- sd_buff_dout  out  8  read data to the drive buffer.
- sd_buff_wr  out  1  one-cycle strobe; sd_buff_dout is valid at sd_buff_addr.
- sd_buff_din  in  8  write data from the drive buffer.
- img_blocks  in  MEM_AW-9  image size in blocks.
- img_ro  in  1  image is read-only.
- mem_addr  out  MEM_AW  image byte address.
- mem_rd  out  1  memory read request, held until mem_ready.
- mem_wr  out  1  memory write request, held until mem_ready.
- mem_din  out  8  write data to memory.
- mem_dout  in  8  read data; valid in the mem_ready cycle.
- mem_ready  in  1  memory transaction complete.

Behaviour:
- Reset, when reset_n is low at an edge:
  - state goes to IDLE;
  - sd_ack, sd_buff_wr, mem_rd and mem_wr go to 0;
  - sd_buff_addr, sd_buff_dout, mem_addr and mem_din go to 0.
  - Reset mid-transfer abandons the block and any pending memory transaction. The memory side must tolerate a dropped request.
- States: IDLE, RD_FETCH, RD_PUT, RD_GAP, WR_ADDR, WR_WAIT, WR_STORE, WR_GAP, DONE.
- IDLE:
  - If sd_rd or sd_wr is high, the request is accepted: latch sd_lba and op, set idx=0, and assert sd_ack on the next edge.
  - sd_rd wins if both are high.
  - The drive must drop its request once it sees sd_ack.
- In range means lba < img_blocks, compared at full 32 bits with img_blocks zero-extended. mem_addr = {lba[MEM_AW-10:0], idx}.
- Read, in range:
  - RD_FETCH asserts mem_rd and holds it until mem_ready.
  - On mem_ready, mem_dout is captured into sd_buff_dout and the state moves to RD_PUT.
  - RD_PUT drives sd_buff_wr=1 for exactly one cycle, with sd_buff_addr=idx.
  - RD_GAP waits PACE cycles. If idx=511 it goes to DONE; otherwise idx++ and back to RD_FETCH.
- Read, out of range: no memory access. Each byte is 0x00 through RD_PUT/RD_GAP.
- Write:
  - WR_ADDR drives sd_buff_addr=idx.
  - WR_WAIT holds for RD_LAT cycles, then samples sd_buff_din into mem_din.
  - WR_STORE asserts mem_wr until mem_ready.
  - If out of range or img_ro=1, WR_STORE completes immediately without asserting mem_wr, and the data is discarded.
  - WR_GAP waits PACE cycles. If idx=511 it goes to DONE; otherwise idx++ and back to WR_ADDR.
  - sd_buff_wr stays 0 throughout a write.
- DONE: sd_ack drops; return to IDLE. sd_ack is low for at least 1 cycle between blocks. A request still high in IDLE starts a new block.
- sd_lba changes during a transfer are ignored. sd_rd/sd_wr toggling during a transfer is ignored.
- idx is 9 bits. After byte 511 the transfer terminates and idx does not wrap into a second pass.
- Minimum read block, with PACE=0 and mem_ready in the same cycle as the request: 3 cycles/byte, plus the accept and DONE cycles.

Decomposition:
- Shared package c1541_pkg holds:
  - the state enum;
  - BLK_BYTES=512 and BLK_AW=9;
  - the MEM_AW default.
- One sub-module, c1541_sd_pacer: a loadable down-counter generating the RD_LAT and PACE waits, with load/count/zero handshake.
- Remaining logic is the FSM in c1541_sd_server.

Test Plan:
1. Read in range: img_blocks=683, memory byte[a]=a[7:0]^a[15:8]; sd_rd, lba=357.
   - sd_ack stays high for the whole transfer.
   - 512 sd_buff_wr strobes, addresses 0..511 in order; dout matches memory at 357*512+idx; mem_rd held until mem_ready with ready delays of 0..5.
   - sd_ack then low for at least 1 cycle.
2. Read out of range: lba=683.
   - 512 strobes, all bytes 0x00.
   - mem_rd never asserted.
3. Write, RD_LAT=2, drive-buffer model with 2-cycle latency holding pattern 0xFF-idx; sd_wr, lba=18.
   - Memory 18*512..+511 equals the pattern.
   - sd_buff_wr never asserted.
4. Write with img_ro=1, then again with lba=700.
   - sd_ack runs a full 512-index cycle.
   - mem_wr is never asserted; memory is unchanged.
5. sd_rd and sd_wr both high, lba=1: the read is performed.
   - Then hold sd_rd high through DONE: a second read of lba=1 starts after exactly 1 cycle of ack low.
6. reset_n low at byte 200 of a read.
   - Next edge: all outputs 0, state IDLE.
   - A subsequent read of lba=2 completes correctly from idx 0.
